// File: rtl/imem_prog_if.sv
// Load-stream and fetch-port bundle for the run-time loadable instruction memory.
interface imem_prog_if #(
  parameter int unsigned N  = 32,
  parameter int unsigned AW = 6
);
  // load stream
  logic          load_start;
  logic          ld_valid;
  logic [N-1:0]  ld_data;
  logic          ld_last;
  logic          ld_ready;
  // fetch port
  logic          fetch_en;
  logic [AW-1:0] addr;
  logic [N-1:0]  q;
  logic          q_valid;
  // status
  logic          busy;
  logic [AW:0]   count;

  modport master (
    output load_start, ld_valid, ld_data, ld_last, fetch_en, addr,
    input  ld_ready, q, q_valid, busy, count
  );

  modport slave (
    input  load_start, ld_valid, ld_data, ld_last, fetch_en, addr,
    output ld_ready, q, q_valid, busy, count
  );
endinterface

// File: rtl/imem_prog.sv
// Run-time loadable instruction memory: streamed program load, 1-cycle registered fetch.
module imem_prog #(
  parameter int unsigned N  = 32,
  parameter int unsigned AW = 6
) (
  input  logic        clk,
  input  logic        reset,
  imem_prog_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wr_en;
  logic [N-1:0]    mem [DEPTH];
  logic [N-1:0]    q_q;
  logic            q_valid_q;
  logic            in_load;
  logic            beat_ok;
  logic            addr_hit;

  assign in_load  = (state_q == LOAD);
  assign beat_ok  = bus.ld_valid & in_load & ~bus.load_start;
  assign addr_hit = ({1'b0, bus.addr} < count_q);

  // State, write pointer and program length registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Next-state: load_start always restarts; accepted beats advance the write pointer
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    if (bus.load_start) begin
      state_d = LOAD;
      wptr_d  = '0;
      count_d = '0;
    end else if (beat_ok) begin
      wr_en   = 1'b1;
      count_d = CW'(wptr_q) + CW'(1);
      if (bus.ld_last || (wptr_q == AW'(DEPTH - 1))) begin
        state_d = RUN;
      end else begin
        wptr_d = wptr_q + AW'(1);
      end
    end
  end

  // Program storage: write-only from the load side, no reset so it maps to RAM
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr_q] <= bus.ld_data;
    end
  end

  // Fetch port: served only in RUN; words past the program length read as zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else if (state_q == RUN) begin
      q_valid_q <= bus.fetch_en;
      if (bus.fetch_en) begin
        q_q <= addr_hit ? mem[bus.addr] : '0;
      end
    end else begin
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end
  end

  assign bus.ld_ready = in_load;
  assign bus.busy     = in_load;
  assign bus.count    = count_q;
  assign bus.q        = q_q;
  assign bus.q_valid  = q_valid_q;

endmodule

// File: tb/tb_imem_prog.sv
// Directed self-checking bench for imem_prog.
module tb_imem_prog;

  localparam int unsigned N  = 32;
  localparam int unsigned AW = 6;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  imem_prog_if #(.N(N), .AW(AW)) bus ();

  imem_prog #(.N(N), .AW(AW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] eq, input logic eqv,
                         input logic ebusy, input logic [6:0] ecount);
    chk({tag, ".q"},       64'(bus.q),        64'(eq));
    chk({tag, ".q_valid"}, 64'(bus.q_valid),  64'(eqv));
    chk({tag, ".busy"},    64'(bus.busy),     64'(ebusy));
    chk({tag, ".ready"},   64'(bus.ld_ready), 64'(ebusy));
    chk({tag, ".count"},   64'(bus.count),    64'(ecount));
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic start_load();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic fetch(input logic [5:0] a);
    bus.fetch_en = 1'b1;
    bus.addr     = a;
    tick();
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n          = 1'b0;
    bus.load_start = 1'b0;
    bus.ld_valid   = 1'b0;
    bus.ld_data    = '0;
    bus.ld_last    = 1'b0;
    bus.fetch_en   = 1'b0;
    bus.addr       = '0;

    // reset state
    #12;
    chk_out("reset", 32'h0, 1'b0, 1'b0, 7'd0);
    rst_n = 1'b1;
    tick();

    // 3-word program, ready high for each beat
    start_load();
    chk_out("ld3_start", 32'h0, 1'b0, 1'b1, 7'd0);
    beat(32'hf8000001, 1'b0);
    chk_out("ld3_b0", 32'h0, 1'b0, 1'b1, 7'd1);
    beat(32'hf8008002, 1'b0);
    chk_out("ld3_b1", 32'h0, 1'b0, 1'b1, 7'd2);
    beat(32'h8b050083, 1'b1);
    chk_out("ld3_b2", 32'h0, 1'b0, 1'b0, 7'd3);

    // back-to-back fetches, last address beyond program length
    fetch(6'd0); chk_out("f0", 32'hf8000001, 1'b1, 1'b0, 7'd3);
    fetch(6'd1); chk_out("f1", 32'hf8008002, 1'b1, 1'b0, 7'd3);
    fetch(6'd2); chk_out("f2", 32'h8b050083, 1'b1, 1'b0, 7'd3);
    fetch(6'd3); chk_out("f3", 32'h0,        1'b1, 1'b0, 7'd3);
    fetch(6'd2); chk_out("f2b", 32'h8b050083, 1'b1, 1'b0, 7'd3);
    bus.fetch_en = 1'b0;
    tick();
    chk_out("f_hold", 32'h8b050083, 1'b0, 1'b0, 7'd3);

    // gapped beats with fetch held throughout the load
    start_load();
    bus.fetch_en = 1'b1;
    bus.addr     = 6'd0;
    beat(32'h11110001, 1'b0);
    chk_out("gap_b0", 32'h0, 1'b0, 1'b1, 7'd1);
    bus.ld_data = 32'hdeadbeef;
    tick();
    chk_out("gap_idle", 32'h0, 1'b0, 1'b1, 7'd1);
    beat(32'h22220002, 1'b1);
    chk_out("gap_b1", 32'h0, 1'b0, 1'b0, 7'd2);
    tick();
    chk_out("gap_f0", 32'h11110001, 1'b1, 1'b0, 7'd2);
    fetch(6'd1); chk_out("gap_f1", 32'h22220002, 1'b1, 1'b0, 7'd2);
    fetch(6'd2); chk_out("gap_f2", 32'h0,        1'b1, 1'b0, 7'd2);
    bus.fetch_en = 1'b0;

    // restart in RUN concurrent with a fetch: old program still served
    start_load();
    beat(32'hf8000001, 1'b0);
    beat(32'hf8008002, 1'b0);
    beat(32'h8b050083, 1'b1);
    chk_out("rl_done", 32'h0, 1'b0, 1'b0, 7'd3);
    bus.load_start = 1'b1;
    fetch(6'd1);
    bus.load_start = 1'b0;
    bus.fetch_en   = 1'b0;
    chk_out("rl_same", 32'hf8008002, 1'b1, 1'b1, 7'd0);
    tick();
    chk_out("rl_next", 32'h0, 1'b0, 1'b1, 7'd0);
    beat(32'hb400001f, 1'b1);
    chk_out("rl_one", 32'h0, 1'b0, 1'b0, 7'd1);
    fetch(6'd1); chk_out("rl_f1", 32'h0,        1'b1, 1'b0, 7'd1);
    fetch(6'd0); chk_out("rl_f0", 32'hb400001f, 1'b1, 1'b0, 7'd1);
    bus.fetch_en = 1'b0;

    // full-depth load without ld_last ends in RUN with count=DEPTH
    start_load();
    for (int i = 0; i < 64; i++) begin
      if (i == 63) chk_out("full_b62", 32'h0, 1'b0, 1'b1, 7'd63);
      beat(32'(i), 1'b0);
    end
    chk_out("full_done", 32'h0, 1'b0, 1'b0, 7'd64);
    fetch(6'd63); chk_out("full_f63", 32'd63, 1'b1, 1'b0, 7'd64);
    fetch(6'd62); chk_out("full_f62", 32'd62, 1'b1, 1'b0, 7'd64);
    bus.fetch_en = 1'b0;

    // asynchronous reset mid-load
    start_load();
    beat(32'h0000aaaa, 1'b0);
    beat(32'h0000bbbb, 1'b0);
    chk_out("rst_pre", 32'h0, 1'b0, 1'b1, 7'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_async", 32'h0, 1'b0, 1'b0, 7'd0);
    rst_n = 1'b1;
    fetch(6'd0);
    chk_out("rst_fetch", 32'h0, 1'b0, 1'b0, 7'd0);
    bus.fetch_en = 1'b0;
    beat(32'h0000cccc, 1'b1);
    chk_out("rst_nobeat", 32'h0, 1'b0, 1'b0, 7'd0);

    // beat coincident with load_start is discarded
    bus.load_start = 1'b1;
    beat(32'h0000dddd, 1'b1);
    bus.load_start = 1'b0;
    chk_out("ls_drop", 32'h0, 1'b0, 1'b1, 7'd0);
    beat(32'h0000eeee, 1'b1);
    chk_out("ls_one", 32'h0, 1'b0, 1'b0, 7'd1);
    fetch(6'd0); chk_out("ls_f0", 32'h0000eeee, 1'b1, 1'b0, 7'd1);
    bus.fetch_en = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
